host_bus_master: RTL
====================

// Module: host_bus_master
// PURPOSE
//  Bus initiator for the host register interface (nCS/nWE/nOE, 21-bit address, 16-bit data).
//  Converts single-beat valid/ready requests into timed, glitch-free, fully registered strobes.
//  Drives the register-mapped FPGA peripherals (const/cmd registers at 0x00000-0x01000) from
//  on-chip logic or a bench, replacing the external CPU.
// PARAMETERS
//  SETUP_CYC   2  cycles nCS/ADD/HDI valid before strobe; 1..15
//  STROBE_CYC  4  cycles nWE or nOE held low; 1..15
//  HOLD_CYC    1  cycles nCS/ADD/HDI held after strobe release; 0..15 (0 = state skipped)
//  TURN_CYC    1  cycles nCS high before the next access may start; 0..15 (0 = state skipped)
// PORTS
//  clk        in   1   system clock
//  nRESET     in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid & req_ready; high only in IDLE
//  req_write  in   1   1 = write, 0 = read
//  req_size   in   1   1 = 32-bit access (HOST_BUS_BURST32_EN only; ignored otherwise)
//  req_addr   in   21  byte address, bit 0 ignored
//  req_wdata  in   32  write data; [15:0] used for 16-bit access
//  rsp_valid  out  1   one-cycle pulse at transaction completion (read and write)
//  rsp_rdata  out  32  read data, valid with rsp_valid; held until next read completes
//  busy       out  1   ~req_ready
//  HOST_nCS   out  1   chip select, active low
//  HOST_nWE   out  1   write strobe, active low
//  HOST_nOE   out  1   output enable, active low
//  HOST_ADD   out  21  address
//  HDI        out  16  data to responder
//  HDO        in   16  data from responder (registered on the responder side)
// BEHAVIOUR
//  Reset (async, immediate):
//   - HOST_nCS/nWE/nOE=1; HOST_ADD=0; HDI=0; rsp_valid=0; rsp_rdata=0.
//   - State IDLE, so req_ready=1 and busy=0.
//   - An in-flight access is dropped with no rsp_valid.
//  FSM: IDLE -> SETUP -> STROBE -> HOLD -> TURN -> IDLE. Cycle counter is 4 bits.
//   - IDLE: on accept, latch write/addr/wdata/size; go to SETUP next cycle.
//   - SETUP (SETUP_CYC): nCS=0, ADD driven. HDI driven on write, otherwise 0. nWE=nOE=1.
//   - STROBE (STROBE_CYC): nWE=0 on write or nOE=0 on read; nCS/ADD/HDI unchanged.
//     Read samples HDO into rsp_rdata[15:0] at the clock edge ending the last STROBE cycle.
//   - HOLD (HOLD_CYC): nWE=nOE=1; nCS/ADD/HDI held.
//   - TURN (TURN_CYC): nCS=1; ADD/HDI keep their last values.
//   - rsp_valid pulses for 1 cycle: the first cycle after the last HOLD cycle.
//  Invariants:
//   - nWE and nOE are never low together.
//   - ADD/HDI never change while nCS=0.
//   - All bus outputs come straight from flops.
//  Timing:
//   - Accept-to-ready latency = 1+SETUP_CYC+STROBE_CYC+HOLD_CYC+TURN_CYC (defaults: 9).
//   - Back-to-back: a request held valid is accepted in the IDLE cycle after TURN.
//  Requests while busy are not accepted; the requester holds its request.
//  rsp_rdata[31:16]=0 for 16-bit reads. Write responses leave rsp_rdata unchanged.
//  SETUP_CYC or STROBE_CYC = 0 is illegal; simulation $error at time 0.
// CONFIGURATION
//  HOST_BUS_BURST32_EN defined, req_size=1:
//   - Two 16-bit accesses: low half at {addr[20:2],2'b00} (wdata[15:0]), then high half at +2 (wdata[31:16]).
//   - Full SETUP..TURN sequence for each half; TURN is always applied between the halves.
//   - Reads assemble {high,low} into rsp_rdata.
//   - Single rsp_valid, after the second access.
//  HOST_BUS_BURST32_EN undefined: req_size ignored; every request is one 16-bit access.
// TESTING
//  1. nRESET low -> nCS/nWE/nOE=1, ADD=0, HDI=0, req_ready=1, rsp_valid=0, rsp_rdata=0.
//  2. Write 0x01000 / 0x0003 (accept cycle 0, defaults) -> nCS=0 cycles 1-7, nWE=0 exactly cycles 3-6,
//     ADD=0x01000, HDI=0x0003 throughout; nOE=1 always; rsp_valid cycle 8; req_ready cycle 9.
//  3. Read 0x00004, responder model returns 0xBEEF -> nOE=0 for 4 cycles;
//     rsp_valid with rsp_rdata=0x0000BEEF.
//  4. Two writes with req_valid held -> second nCS fall exactly TURN_CYC+1 cycles after first nCS rise; no overlap.
//  5. nRESET pulsed mid-STROBE -> strobes/nCS high immediately, no rsp_valid;
//     next write 0x00002 / 0x00AA completes normally.
//  6. HOST_BUS_BURST32_EN: 32-bit write 0x12345678 to 0x00000 -> 0x00000/0x5678 then 0x00002/0x1234;
//     one rsp_valid.

Source files
------------

// File: rtl/host_bus_master.sv
// Host register-bus initiator: turns single-beat valid/ready requests into registered nCS/nWE/nOE cycles.
// Define HOST_BUS_BURST32_EN to let req_size=1 issue a 32-bit access as two 16-bit halves.
module host_bus_master #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 1
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_size,
    input  logic [20:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic        HOST_nCS,
    output logic        HOST_nWE,
    output logic        HOST_nOE,
    output logic [20:0] HOST_ADD,
    output logic [15:0] HDI,
    input  logic [15:0] HDO
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 1 || STROBE_CYC > 15) begin : g_bad_active
        $error("host_bus_master: SETUP_CYC and STROBE_CYC must be in 1..15");
    end
    if (HOLD_CYC < 0 || HOLD_CYC > 15 || TURN_CYC < 0 || TURN_CYC > 15) begin : g_bad_idle
        $error("host_bus_master: HOLD_CYC and TURN_CYC must be in 0..15");
    end

    // Counters load duration-1 on state entry and the state ends when they reach zero.
    localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TURN_LAST   = 4'(TURN_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        ncs_q, ncs_d;
    logic        nwe_q, nwe_d;
    logic        noe_q, noe_d;
    logic [20:0] add_q, add_d;
    logic [15:0] hdi_q, hdi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        req_ready_q, req_ready_d;
    logic        busy_q, busy_d;
    logic        cnt_last;
    logic        access_end;

`ifdef HOST_BUS_BURST32_EN
    // Between the two halves nCS must go high for at least one cycle.
    localparam logic [3:0] GAP_LAST = (TURN_CYC == 0) ? 4'd0 : TURN_LAST;
    logic        size_q, size_d;
    logic        half_q, half_d;
    logic [15:0] wdata_hi_q, wdata_hi_d;
    logic [15:0] rdata_lo_q, rdata_lo_d;
    logic        more_half;
    logic        unused_in;
    assign more_half = size_q & ~half_q;
    assign unused_in = req_addr[0];
`else
    logic        unused_in;
    assign unused_in = ^{req_size, req_wdata[31:16], req_addr[0]};
`endif

    assign cnt_last = (cnt_q == 4'd0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        add_d       = add_q;
        hdi_d       = hdi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        access_end  = 1'b0;
`ifdef HOST_BUS_BURST32_EN
        size_d      = size_q;
        half_d      = half_q;
        wdata_hi_d  = wdata_hi_q;
        rdata_lo_d  = rdata_lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LAST;
                    write_d = req_write;
                    hdi_d   = req_write ? req_wdata[15:0] : 16'h0000;
`ifdef HOST_BUS_BURST32_EN
                    add_d      = req_size ? {req_addr[20:2], 2'b00} : {req_addr[20:1], 1'b0};
                    size_d     = req_size;
                    half_d     = 1'b0;
                    wdata_hi_d = req_wdata[31:16];
`else
                    add_d   = {req_addr[20:1], 1'b0};
`endif
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_d = STROBE;
                    cnt_d   = STROBE_LAST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            STROBE: begin
                if (cnt_last) begin
                    if (!write_q) begin
`ifdef HOST_BUS_BURST32_EN
                        if (half_q)      rsp_rdata_d = {HDO, rdata_lo_q};
                        else if (size_q) rdata_lo_d  = HDO;
                        else             rsp_rdata_d = {16'h0000, HDO};
`else
                        rsp_rdata_d = {16'h0000, HDO};
`endif
                    end
                    if (HOLD_CYC != 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LAST;
                    end else begin
                        access_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                if (cnt_last) access_end = 1'b1;
                else          cnt_d      = cnt_q - 4'd1;
            end
            TURN: begin
                if (cnt_last) begin
`ifdef HOST_BUS_BURST32_EN
                    if (more_half) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LAST;
                        half_d  = 1'b1;
                        add_d   = {add_q[20:2], 2'b10};
                        hdi_d   = write_q ? wdata_hi_q : 16'h0000;
                    end else
`endif
                    begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Response only after the final half; an intermediate half goes straight to the gap.
        if (access_end) begin
`ifdef HOST_BUS_BURST32_EN
            if (more_half) begin
                state_d = TURN;
                cnt_d   = GAP_LAST;
            end else
`endif
            begin
                rsp_valid_d = 1'b1;
                if (TURN_CYC != 0) begin
                    state_d = TURN;
                    cnt_d   = TURN_LAST;
                end else begin
                    state_d = IDLE;
                end
            end
        end

        ncs_d       = !(state_d == SETUP || state_d == STROBE || state_d == HOLD);
        nwe_d       = !(state_d == STROBE && write_d);
        noe_d       = !(state_d == STROBE && !write_d);
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            ncs_q       <= 1'b1;
            nwe_q       <= 1'b1;
            noe_q       <= 1'b1;
            add_q       <= 21'h0;
            hdi_q       <= 16'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef HOST_BUS_BURST32_EN
            size_q      <= 1'b0;
            half_q      <= 1'b0;
            wdata_hi_q  <= 16'h0;
            rdata_lo_q  <= 16'h0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            ncs_q       <= ncs_d;
            nwe_q       <= nwe_d;
            noe_q       <= noe_d;
            add_q       <= add_d;
            hdi_q       <= hdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
`ifdef HOST_BUS_BURST32_EN
            size_q      <= size_d;
            half_q      <= half_d;
            wdata_hi_q  <= wdata_hi_d;
            rdata_lo_q  <= rdata_lo_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HOST_nCS  = ncs_q;
    assign HOST_nWE  = nwe_q;
    assign HOST_nOE  = noe_q;
    assign HOST_ADD  = add_q;
    assign HDI       = hdi_q;

endmodule
